// File: rtl/divider_unit_if.sv
// Request/response bundle for the iterative divide/remainder unit.
// master issues the request; slave (the divider) returns the result.
interface divider_unit_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      dividend;
  logic [WIDTH-1:0]      divisor;
  logic [REG_ADDR_W-1:0] rd_i;
  logic                  ready;
  logic                  valid_o;
  logic [WIDTH-1:0]      result;
  logic [REG_ADDR_W-1:0] rd_o;

  modport master (
    output start, op, dividend, divisor, rd_i,
    input  ready, valid_o, result, rd_o
  );

  modport slave (
    input  start, op, dividend, divisor, rd_i,
    output ready, valid_o, result, rd_o
  );
endinterface

// File: rtl/divider_unit.sv
// RV32M DIV/DIVU/REM/REMU, restoring shift-subtract, one bit per cycle.
// Option: DIVIDER_EARLY_OUT_EN skips CALC for div-by-zero / overflow.
module divider_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic            clk,
  input logic            resetn,
  divider_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [1:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [WIDTH-1:0]      dvs;
  logic [WIDTH-1:0]      rem;
  logic [WIDTH-1:0]      quo;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      res_q;
  logic [REG_ADDR_W-1:0] rdo_q;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             dz;
  logic             ovf;
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] fin;

  assign bus.ready   = (state == IDLE);
  assign bus.valid_o = (state == DONE);
  assign bus.result  = res_q;
  assign bus.rd_o    = rdo_q;

  // operand signs, magnitudes, special cases and one restoring step
  always_comb begin
    sgn   = ~op_q[0];
    a_neg = sgn & a_q[WIDTH-1];
    b_neg = sgn & b_q[WIDTH-1];
    a_abs = a_neg ? -a_q : a_q;
    b_abs = b_neg ? -b_q : b_q;
    dz    = (b_q == '0);
    ovf   = sgn & (a_q == {1'b1, {(WIDTH-1){1'b0}}})
                & (&b_q);
    sh    = {rem, quo[WIDTH-1]};
    ge    = (sh >= {1'b0, dvs});
    rem_n = ge ? WIDTH'(sh - {1'b0, dvs})
               : sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
    q_fix = (a_neg ^ b_neg) ? -quo_n : quo_n;
    r_fix = a_neg ? -rem_n : rem_n;
    if (dz) begin
      q_fix = '1;
      r_fix = a_q;
    end
    if (ovf) begin
      q_fix = {1'b1, {(WIDTH-1){1'b0}}};
      r_fix = '0;
    end
    fin = op_q[1] ? r_fix : q_fix;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.start) nxt = PREP;
`ifdef DIVIDER_EARLY_OUT_EN
      PREP: nxt = (dz | ovf) ? DONE : CALC;
`else
      PREP: nxt = CALC;
`endif
      CALC: if (cnt == '0) nxt = DONE;
      DONE: nxt = IDLE;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      res_q <= '0;
      rdo_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q  <= bus.dividend;
            b_q  <= bus.divisor;
            op_q <= bus.op;
            rd_q <= bus.rd_i;
          end
        end
        PREP: begin
          dvs <= b_abs;
          quo <= a_abs;
          rem <= '0;
          cnt <= CW'(WIDTH-1);
`ifdef DIVIDER_EARLY_OUT_EN
          if (dz | ovf) begin
            res_q <= fin;
            rdo_q <= rd_q;
          end
`endif
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res_q <= fin;
            rdo_q <= rd_q;
          end
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: directed RV32M vectors,
// latency, busy-start rejection and mid-operation reset.
module tb_divider_unit;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  divider_unit_if bus ();

  divider_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

`ifdef DIVIDER_EARLY_OUT_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 34;
`endif
  localparam int NLAT = 34;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_idle = 1'b0;
  bit   chk_end = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every result pulse against the scoreboard
  always @(negedge clk) begin
    if (bus.valid_o) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: result=%h rd=%0d cyc=%0d",
                 bus.result, bus.rd_o, cyc);
      end else begin
        e = q.pop_front();
        if (bus.result !== e.res || bus.rd_o !== e.rd
            || cyc != e.cyc) begin
          n_err++;
          $display("FAIL %s: got res=%h rd=%0d cyc=%0d, want res=%h rd=%0d cyc=%0d",
                   e.name, bus.result, bus.rd_o, cyc,
                   e.res, e.rd, e.cyc);
        end
      end
    end
    if (chk_idle) begin
      n_cmp++;
      if (bus.ready !== 1'b1 || bus.valid_o !== 1'b0
          || bus.result !== 32'h0 || bus.rd_o !== 5'd0) begin
        n_err++;
        $display("FAIL reset_state: got ready=%b valid=%b res=%h rd=%0d, want 1 0 0 0",
                 bus.ready, bus.valid_o, bus.result, bus.rd_o);
      end
    end
    if (chk_end) begin
      n_cmp++;
      if (q.size() != 0) begin
        n_err++;
        $display("FAIL missing_results: got %0d outstanding, want 0",
                 q.size());
      end
    end
  end

  task automatic wait_ready(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) done = 1'b1;
    end
    if (!done) begin
      $display("FAIL %s_timeout: got ready=0, want 1", name);
      $fatal(1, "timeout");
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd,
                       input logic [31:0] res,
                       input int lat,
                       input int inj,
                       input string name);
    exp_t x;
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.rd_i     = rd;
    x.res  = res;
    x.rd   = rd;
    x.cyc  = cyc + lat;
    x.name = name;
    q.push_back(x);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0000_0003;
    bus.rd_i     = 5'd31;
    if (inj > 0) begin
      repeat (inj - 1) @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.op       = 2'b00;
      bus.dividend = 32'd85;
      bus.divisor  = 32'd5;
      bus.rd_i     = 5'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    wait_ready(name);
  endtask

  initial begin
    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.rd_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn   = 1'b1;
    chk_idle = 1'b1;
    @(posedge clk);
    #1;
    chk_idle = 1'b0;

    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd5,
          32'hFFFF_FFFD, NLAT, 0, "div_7_m2");
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6,
          32'h0000_0001, NLAT, 0, "rem_7_m2");
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7,
          32'hFFFF_FFFD, NLAT, 0, "div_m7_2");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8,
          32'hFFFF_FFFF, NLAT, 0, "rem_m7_2");
    issue(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd10,
          32'hFFFF_FFFF, NLAT, 0, "divu_max_1");
    issue(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd11,
          32'h0000_000F, NLAT, 0, "remu_max_16");
    issue(2'b01, 32'd100, 32'd7, 5'd0,
          32'd14, NLAT, 0, "divu_100_7_x0");
    issue(2'b00, 32'h1234, 32'd0, 5'd12,
          32'hFFFF_FFFF, SLAT, 0, "div_by_zero");
    issue(2'b10, 32'h8000_0005, 32'd0, 5'd13,
          32'h8000_0005, SLAT, 0, "rem_by_zero");
    issue(2'b00, 32'hFFFF_FFF9, 32'd0, 5'd14,
          32'hFFFF_FFFF, SLAT, 0, "div_neg_by_zero");
    issue(2'b01, 32'd5, 32'd0, 5'd15,
          32'hFFFF_FFFF, SLAT, 0, "divu_by_zero");
    issue(2'b11, 32'hFFFF_FFF0, 32'd0, 5'd16,
          32'hFFFF_FFF0, SLAT, 0, "remu_by_zero");
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17,
          32'h8000_0000, SLAT, 0, "div_overflow");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18,
          32'h0000_0000, SLAT, 0, "rem_overflow");
    issue(2'b11, 32'd100, 32'd7, 5'd19,
          32'd2, NLAT, 5, "busy_start_ignored");

    // in-flight op dropped by reset: no scoreboard entry
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.op       = 2'b01;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    bus.rd_i     = 5'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    chk_idle = 1'b1;
    @(posedge clk);
    #1;
    chk_idle = 1'b0;
    repeat (40) @(posedge clk);

    issue(2'b01, 32'd100, 32'd7, 5'd21,
          32'd14, NLAT, 0, "after_reset");

    repeat (5) @(posedge clk);
    #1;
    chk_end = 1'b1;
    @(posedge clk);
    #1;
    chk_end = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
